// File: rtl/decoder_pkg.sv
// Shared types and the index-to-1-hot decode helper for onehot_decoder_pipe.
package decoder_pkg;

   // Occupancy of the output register pair: main (M) and skid (S).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Widest lane count the decode helper can produce; callers slice down to WIDTH.
   localparam int unsigned DEC_MAX_W   = 256;
   localparam int unsigned DEC_IDX_W   = $clog2(DEC_MAX_W);

   typedef struct packed {
      logic                 err;
      logic [DEC_MAX_W-1:0] vec;
   } dec_t;

   // Decode idx into a 1-hot vector of 'width' lanes. A disabled beat yields an
   // all-zero vector; an enabled beat whose index does not name a lane yields an
   // all-zero vector with err set.
   function automatic dec_t onehot_decode(
      input logic [31:0] idx,
      input logic        en,
      input int unsigned width
   );
      dec_t res;
      res.err = 1'b0;
      res.vec = {DEC_MAX_W{1'b0}};
      if (en) begin
         if (idx < width) begin
            res.vec[idx[DEC_IDX_W-1:0]] = 1'b1;
         end else begin
            res.err = 1'b1;
         end
      end else begin
         res.vec = {DEC_MAX_W{1'b0}};
      end
      return res;
   endfunction

endpackage

// File: rtl/onehot_decoder_pipe_chk.sv
// Simulation-time checks on the decoder's input beats and output vector.
module onehot_decoder_pipe_chk #(
   parameter int WIDTH = 8,
   parameter int SIZE  = 3
) (
   input logic             clk,
   input logic             rst,
   input logic             in_valid,
   input logic [SIZE-1:0]  in_idx,
   input logic             in_en,
   input logic [WIDTH-1:0] out_onehot
);

   a_in_known: assert property (@(posedge clk) disable iff (rst)
      in_valid |-> !$isunknown({in_idx, in_en}))
      else $error("onehot_decoder_pipe: unknown in_idx/in_en on a valid beat");

   a_out_known: assert property (@(posedge clk) disable iff (rst)
      !$isunknown(out_onehot))
      else $error("onehot_decoder_pipe: unknown value on out_onehot");

endmodule

// File: rtl/skid_buffer.sv
// Generic two-entry valid/ready stage. The main register drives the output;
// the skid register catches the beat accepted while the output is stalled, so
// o_ready depends only on registered state and never on i_ready.
module skid_buffer
   import decoder_pkg::*;
#(
   parameter int DATA_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_ready;
   logic              r_valid;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic              w_acc;
   logic              w_dlv;
   logic              w_load_main;
   logic              w_load_skid;
   logic              w_move_skid;

   // Next-state and register-load decisions from the handshakes on both sides.
   always_comb begin
      w_acc       = i_valid & r_ready;
      w_dlv       = r_valid & i_ready;
      w_state_nxt = r_state;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_move_skid = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_acc) begin
               w_state_nxt = ONE;
               w_load_main = 1'b1;
            end else begin
               w_state_nxt = EMPTY;
            end
         end
         ONE: begin
            if (w_acc && w_dlv) begin
               w_state_nxt = ONE;
               w_load_main = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = FULL;
               w_load_skid = 1'b1;
            end else if (w_dlv) begin
               w_state_nxt = EMPTY;
            end else begin
               w_state_nxt = ONE;
            end
         end
         FULL: begin
            if (w_dlv) begin
               w_state_nxt = ONE;
               w_move_skid = 1'b1;
            end else begin
               w_state_nxt = FULL;
            end
         end
         default: begin
            w_state_nxt = EMPTY;
         end
      endcase
   end

   // State register; ready/valid are registered copies of the next occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt != FULL);
         r_valid <= (w_state_nxt != EMPTY);
      end
   end

   // Payload registers: main is refilled from input or skid, skid only on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main <= {DATA_W{1'b0}};
         r_skid <= {DATA_W{1'b0}};
      end else begin
         if (w_load_main) begin
            r_main <= i_data;
         end else if (w_move_skid) begin
            r_main <= r_skid;
         end else begin
            r_main <= r_main;
         end
         if (w_load_skid) begin
            r_skid <= i_data;
         end else begin
            r_skid <= r_skid;
         end
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_data  = r_main;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Binary index to 1-hot decoder with valid/ready on both sides, a registered
// output plus skid entry for full throughput, and a saturating error counter.
module onehot_decoder_pipe
   import decoder_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SIZE      = $clog2(WIDTH),
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SIZE-1:0]      in_idx,
   input  logic                 in_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_onehot,
   output logic                 out_err,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int PAY_W = WIDTH + 1;

   dec_t                 w_dec;
   logic                 w_dec_unused;
   logic [PAY_W-1:0]     w_payload;
   logic [PAY_W-1:0]     w_out_payload;
   logic                 w_out_valid;
   logic                 w_err_inc;
   logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // Decode on the input side so the stored payload is already {err, vector}.
   always_comb begin
      w_dec        = onehot_decode(32'(in_idx), in_en, WIDTH);
      w_payload    = {w_dec.err, w_dec.vec[WIDTH-1:0]};
      w_dec_unused = ^w_dec;
   end

   skid_buffer #(
      .DATA_W (PAY_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_payload),
      .o_valid (w_out_valid),
      .i_ready (out_ready),
      .o_data  (w_out_payload)
   );

   assign out_valid  = w_out_valid;
   assign out_err    = w_out_payload[WIDTH];
   assign out_onehot = w_out_payload[WIDTH-1:0];

   // Error counter next value: clear wins over hold, then a delivered error counts.
   always_comb begin
      w_err_inc = w_out_valid & out_ready & w_out_payload[WIDTH];
      if (err_clr) begin
         if (w_err_inc) begin
            w_err_cnt_nxt = ERR_CNT_W'(1'b1);
         end else begin
            w_err_cnt_nxt = {ERR_CNT_W{1'b0}};
         end
      end else if (w_err_inc && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
         w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1'b1);
      end else begin
         w_err_cnt_nxt = r_err_cnt;
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= {ERR_CNT_W{1'b0}};
      end else begin
         r_err_cnt <= w_err_cnt_nxt;
      end
   end

   assign err_count = r_err_cnt;

   onehot_decoder_pipe_chk #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_idx     (in_idx),
      .in_en      (in_en),
      .out_onehot (out_onehot)
   );

endmodule

// File: doc/onehot_decoder_pipe.md
Name: onehot_decoder_pipe

Overview:
- Binary index to 1-hot vector decoder with valid/ready handshakes on both sides; the inverse of the team's 1-hot-to-index Encoder.
- Registered output stage plus 1-entry skid buffer: full throughput (1 transfer/cycle), with backpressure that does not combinationally couple out_ready to in_ready.
- Flags out-of-range indices and keeps a saturating error count.
- Used wherever a scheduler or arbiter index must drive per-lane enables (way selects, port grants).

Parameters:
- WIDTH, 8, number of 1-hot output lanes; must be >= 2.
- SIZE, $clog2(WIDTH), index width.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  decoder can accept a beat.
- in_idx  input  SIZE  binary lane index.
- in_en  input  1  decode enable; 0 means a beat with an all-zero vector.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the output beat.
- out_onehot  output  WIDTH  decoded vector.
- out_err  output  1  beat carried in_en=1 with in_idx >= WIDTH.
- err_clr  input  1  synchronous clear of err_count.
- err_count  output  ERR_CNT_W  saturating count of delivered error beats.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_onehot=0, out_err=0, err_count=0, in_ready=0.
  - State = EMPTY.
  - in_ready goes to 1 on the first cycle after rst deasserts.
  - Reset mid-operation discards any held beats without delivering them.
- Decode function, applied at acceptance:
  - in_en=0 -> vector 0, err 0.
  - in_en=1 and in_idx<WIDTH -> vector = 1<<in_idx, err 0.
  - in_en=1 and in_idx>=WIDTH -> vector 0, err 1 (only possible when WIDTH is not a power of 2).
  - Exactly one bit set whenever err=0 and in_en=1.
- Acceptance: a beat is accepted when in_valid && in_ready at the clock edge.
- Latency: exactly 1 cycle from acceptance to out_valid when the output stage is empty.
- Delivery: a beat is delivered when out_valid && out_ready.
- Output hold: while out_valid && !out_ready, out_onehot and out_err hold stable; out_valid never drops without delivery.
- State machine (main output register M, skid register S):
  - EMPTY: in_ready=1, out_valid=0. On accept -> ONE (beat into M).
  - ONE: in_ready=1, out_valid=1.
    - accept && deliver -> ONE (new beat into M).
    - accept && !deliver -> FULL (new beat into S).
    - !accept && deliver -> EMPTY.
    - otherwise stay in ONE.
  - FULL: in_ready=0, out_valid=1.
    - deliver -> ONE (S moves to M).
    - otherwise stay in FULL.
- Registering: in_ready is a function of registered state only, never of out_ready.
- Ordering: beats are delivered strictly in acceptance order; no beat is lost or duplicated.
- err_count:
  - Increments on each delivered beat with out_err=1.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr and an increment in the same cycle -> count = 1 (clear then count).
  - err_clr alone -> 0.
- Simulation check: assertion error if in_valid=1 and in_idx or in_en is X/Z. No X may ever propagate to out_onehot.

Decomposition:
- Package decoder_pkg holds:
  - the state enum {EMPTY, ONE, FULL};
  - a function onehot_decode(idx, en), returning vector + err, parameterised by WIDTH through its caller.
- Natural sub-module: skid_buffer. It is a generic 2-entry valid/ready stage, parameterised by payload width, and carries {err, vector}.
- The top instantiates skid_buffer, performs the decode on the input side, and owns the error counter.

Test Plan:
- Reset then stream with out_ready=1:
  - Stimulus: rst for 2 cycles, then WIDTH=8, in_idx 0,1,...,7 back-to-back with in_en=1.
  - Required: in_ready=0 during rst, 1 after; out_onehot 0x01, 0x02, ..., 0x80 on consecutive cycles starting 1 cycle after the first accept; out_err=0 throughout.
- Backpressure:
  - Stimulus: out_ready=0 while sending idx 3 then idx 5.
  - Required: state FULL, in_ready=0, out_onehot holds 0x08.
  - Then out_ready=1 for 2 cycles -> 0x08 then 0x20 delivered, state EMPTY.
- Disabled beat: in_en=0, in_idx=6 -> out_onehot=0x00, out_err=0, err_count unchanged.
- Out of range:
  - Stimulus: WIDTH=5, in_en=1, in_idx=6.
  - Required: out_onehot=0, out_err=1, err_count increments by 1 on delivery only.
- Counter edges:
  - ERR_CNT_W=2, 5 error beats -> err_count saturates at 3.
  - err_clr asserted in the same cycle as an error delivery -> err_count=1.
- Reset mid-operation: state FULL, then rst pulsed -> out_valid=0 on the next cycle; the two held beats are never delivered.
